conv2d_engine: RTL and testbench

//  Parametrised 2-D convolution engine, successor to the fixed-size conv core.

---
 rtl/conv2d_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv2d_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv2d_engine.sv
// conv2d_engine
//   Parametrised 2-D convolution engine. On an accepted cmd_start the job
//   configuration is latched and checked. A valid job then streams one tap
//   address per cycle through a three-stage address / multiply / accumulate
//   pipeline and writes one saturated result per output pixel.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_start                start pulse, only sampled in IDLE
//   cfg_img_w, cfg_img_h     image size 1..255
//   cfg_kernel, cfg_stride   kernel size K (1..KMAX), stride S (0 means 1)
//   cfg_pad, cfg_knum        zero padding P=K/2 when set, kernel count (1..NKMAX)
//   ren, xaddr, xdata        input memory port (1-cycle read latency)
//   waddr, wdata             weight memory port (1-cycle read latency)
//   owen, oaddr, odata       feature map write port
//   cmd_busy, cmd_done       job status; cmd_done is a single-cycle pulse
//   cfg_err                  qualified by cmd_done; 1 = configuration rejected
module conv2d_engine #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int ADDR_W = 18,
  parameter int KMAX   = 7,
  parameter int NKMAX  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic [7:0]               cfg_img_w,
  input  logic [7:0]               cfg_img_h,
  input  logic [3:0]               cfg_kernel,
  input  logic [1:0]               cfg_stride,
  input  logic                     cfg_pad,
  input  logic [3:0]               cfg_knum,
  output logic                     ren,
  output logic [ADDR_W-1:0]        xaddr,
  input  logic signed [DATA_W-1:0] xdata,
  output logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic                     owen,
  output logic [ADDR_W-1:0]        oaddr,
  output logic signed [DATA_W-1:0] odata,
  output logic                     cmd_busy,
  output logic                     cmd_done,
  output logic                     cfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] KMAX_L  = 4'(KMAX);
  localparam logic [3:0] NKMAX_L = 4'(NKMAX);

  // Clamp the accumulator into the DATA_W signed range. No overflow when all
  // bits from the output sign bit upward agree.
  function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-DATA_W:0] top;
    top = a[ACC_W-1:DATA_W-1];
    if (top == '0 || top == '1)
      return a[DATA_W-1:0];
    else if (a[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Floor division by a stride of 1..3; constant divisors keep this cheap.
  function automatic logic [9:0] div_stride(input logic [9:0] v, input logic [1:0] s);
    case (s)
      2'd2:    return v >> 1;
      2'd3:    return v / 10'd3;
      default: return v;
    endcase
  endfunction

  logic [2:0]  state;
  logic [7:0]  img_w, img_h;
  logic [3:0]  ksz, knum;
  logic [1:0]  strd;
  logic        pad_en;
  logic        err_r;
  logic [9:0]  ow_r, oh_r;
  logic [3:0]  k_c, i_c, j_c;
  logic [9:0]  oy_c, ox_c;
  logic [1:0]  drain_c;

  logic [3:0]  pad_amt;
  logic [9:0]  span_w, span_h;
  logic        cfg_bad;
  logic [9:0]  ow_n, oh_n;

  assign pad_amt = pad_en ? {1'b0, ksz[3:1]} : 4'd0;
  assign span_w  = {2'b00, img_w} + {5'b0, pad_amt, 1'b0};
  assign span_h  = {2'b00, img_h} + {5'b0, pad_amt, 1'b0};
  assign cfg_bad = (ksz == 4'd0) || (ksz > KMAX_L) || (knum == 4'd0) || (knum > NKMAX_L) ||
                   ({6'b0, ksz} > span_w) || ({6'b0, ksz} > span_h);
  assign ow_n    = div_stride(span_w - {6'b0, ksz}, strd) + 10'd1;
  assign oh_n    = div_stride(span_h - {6'b0, ksz}, strd) + 10'd1;

  logic        run;
  logic [11:0] ry, cx, r_pos, c_pos;
  logic        row_ok, col_ok, in_b;
  logic        i_last, j_last, ox_last, oy_last, k_last;
  logic        first_p0, last_p0;
  logic [ADDR_W-1:0] map_sz, oaddr_p0;

  assign run    = (state == S_RUN);
  assign ry     = 12'(oy_c) * 12'(strd) + 12'(i_c);
  assign cx     = 12'(ox_c) * 12'(strd) + 12'(j_c);
  assign r_pos  = ry - 12'(pad_amt);
  assign c_pos  = cx - 12'(pad_amt);
  assign row_ok = (ry >= 12'(pad_amt)) && (r_pos < 12'(img_h));
  assign col_ok = (cx >= 12'(pad_amt)) && (c_pos < 12'(img_w));
  assign in_b   = run && row_ok && col_ok;

  assign i_last  = (i_c == ksz - 4'd1);
  assign j_last  = (j_c == ksz - 4'd1);
  assign ox_last = (ox_c == ow_r - 10'd1);
  assign oy_last = (oy_c == oh_r - 10'd1);
  assign k_last  = (k_c == knum - 4'd1);

  assign first_p0 = (i_c == 4'd0) && (j_c == 4'd0);
  assign last_p0  = i_last && j_last;

  assign map_sz   = ADDR_W'(oh_r) * ADDR_W'(ow_r);
  assign oaddr_p0 = ADDR_W'(k_c) * map_sz + ADDR_W'(oy_c) * ADDR_W'(ow_r) + ADDR_W'(ox_c);

  assign ren   = in_b;
  assign xaddr = in_b ? ADDR_W'(r_pos) * ADDR_W'(img_w) + ADDR_W'(c_pos) : '0;
  assign waddr = run ? ADDR_W'(k_c) * ADDR_W'(ksz) * ADDR_W'(ksz) + ADDR_W'(i_c) * ADDR_W'(ksz)
                       + ADDR_W'(j_c) : '0;

  // Control FSM and tap counters (loop order k, oy, ox, i, j).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      img_w   <= '0;
      img_h   <= '0;
      ksz     <= '0;
      knum    <= '0;
      strd    <= '0;
      pad_en  <= 1'b0;
      err_r   <= 1'b0;
      ow_r    <= '0;
      oh_r    <= '0;
      k_c     <= '0;
      i_c     <= '0;
      j_c     <= '0;
      oy_c    <= '0;
      ox_c    <= '0;
      drain_c <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            img_w  <= cfg_img_w;
            img_h  <= cfg_img_h;
            ksz    <= cfg_kernel;
            knum   <= cfg_knum;
            strd   <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
            pad_en <= cfg_pad;
            err_r  <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          ow_r  <= ow_n;
          oh_r  <= oh_n;
          err_r <= cfg_bad;
          k_c   <= '0;
          i_c   <= '0;
          j_c   <= '0;
          oy_c  <= '0;
          ox_c  <= '0;
          state <= cfg_bad ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (j_last) begin
            j_c <= '0;
            if (i_last) begin
              i_c <= '0;
              if (ox_last) begin
                ox_c <= '0;
                if (oy_last) begin
                  oy_c <= '0;
                  if (k_last) begin
                    k_c     <= '0;
                    drain_c <= '0;
                    state   <= S_DRAIN;
                  end else begin
                    k_c <= k_c + 4'd1;
                  end
                end else begin
                  oy_c <= oy_c + 10'd1;
                end
              end else begin
                ox_c <= ox_c + 10'd1;
              end
            end else begin
              i_c <= i_c + 4'd1;
            end
          end else begin
            j_c <= j_c + 4'd1;
          end
        end
        S_DRAIN: begin
          // Three cycles cover the pipeline depth behind the final tap.
          drain_c <= drain_c + 2'd1;
          if (drain_c == 2'd2) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_busy = (state != S_IDLE);
  assign cmd_done = (state == S_DONE);
  assign cfg_err  = (state == S_DONE) && err_r;

  logic                     vld_p1, inb_p1, first_p1, last_p1;
  logic                     vld_p2, first_p2, last_p2;
  logic                     vld_p3;
  logic [ADDR_W-1:0]        oaddr_p1, oaddr_p2, oaddr_p3;
  logic signed [ACC_W-1:0]  x_ext, w_ext, prod_p2, acc;

  assign x_ext = ACC_W'(xdata);
  assign w_ext = ACC_W'(wdata);

  // p0 -> p1: tap issued, memory read in flight
  // p1 -> p2: operands arrive, product registered (zero for padded taps)
  // p2 -> p3: accumulate; the first tap of an output reloads the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      inb_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      vld_p2   <= 1'b0;
      first_p2 <= 1'b0;
      last_p2  <= 1'b0;
      vld_p3   <= 1'b0;
      acc      <= '0;
    end else begin
      vld_p1   <= run;
      inb_p1   <= in_b;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      vld_p3   <= vld_p2 && last_p2;
      if (vld_p2) acc <= first_p2 ? prod_p2 : acc + prod_p2;
    end
  end

  always_ff @(posedge clk) begin
    oaddr_p1 <= oaddr_p0;
    oaddr_p2 <= oaddr_p1;
    oaddr_p3 <= oaddr_p2;
    prod_p2  <= inb_p1 ? x_ext * w_ext : '0;
  end

  // p3: write-back, data and address forced to zero when no write
  assign owen  = vld_p3;
  assign oaddr = vld_p3 ? oaddr_p3 : '0;
  assign odata = vld_p3 ? sat_acc(acc) : '0;

endmodule

// File: tb/tb_conv2d_engine.sv
module tb_conv2d_engine;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 48;
  localparam int ADDR_W = 18;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cmd_start;
  logic [7:0]               cfg_img_w, cfg_img_h;
  logic [3:0]               cfg_kernel, cfg_knum;
  logic [1:0]               cfg_stride;
  logic                     cfg_pad;
  logic                     ren;
  logic [ADDR_W-1:0]        xaddr, waddr, oaddr;
  logic signed [DATA_W-1:0] xdata, wdata, odata;
  logic                     owen, cmd_busy, cmd_done, cfg_err;

  always #5 clk = ~clk;

  conv2d_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .KMAX(7), .NKMAX(8)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_kernel(cfg_kernel),
    .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_knum(cfg_knum),
    .ren(ren), .xaddr(xaddr), .xdata(xdata), .waddr(waddr), .wdata(wdata),
    .owen(owen), .oaddr(oaddr), .odata(odata),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cfg_err(cfg_err)
  );

  logic signed [DATA_W-1:0] xmem [0:63];
  logic signed [DATA_W-1:0] wmem [0:63];

  always @(posedge clk) begin
    xdata <= xmem[xaddr[5:0]];
    wdata <= wmem[waddr[5:0]];
  end

  typedef struct {
    int          w, h, k, s, pad, nk;
    int          xmode, wmode;
    int          n_exp;
    logic [31:0] exp_data [9];
    int          done_cyc;
    int          err;
    int          ren_cnt;
  } vec_t;

  vec_t vecs [8];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input int idx, input bit poke);
    vec_t v;
    int cyc, done_at, nw, rc, pv, err_seen;
    logic [ADDR_W-1:0] ga [16];
    logic [DATA_W-1:0] gd [16];
    v = vecs[idx];
    for (int a = 0; a < 64; a++) begin
      case (v.xmode)
        1:       xmem[a] = a;
        2:       xmem[a] = 32'sh7FFF_FFFF;
        default: xmem[a] = 1;
      endcase
      if (v.wmode == 1) wmem[a] = (a == 0) ? 2 : ((a == 1) ? -2 : 0);
      else              wmem[a] = 1;
    end
    @(negedge clk);
    cfg_img_w  = 8'(v.w);
    cfg_img_h  = 8'(v.h);
    cfg_kernel = 4'(v.k);
    cfg_stride = 2'(v.s);
    cfg_pad    = v.pad[0];
    cfg_knum   = 4'(v.nk);
    cmd_start  = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    cyc = 1; done_at = -1; nw = 0; rc = 0; pv = 0; err_seen = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (cyc == 1) chk($sformatf("v%0d busy", idx), 64'(cmd_busy), 64'd1);
      if (poke && cyc == 10) begin
        cmd_start  = 1'b1;
        cfg_kernel = 4'd1;
      end
      if (poke && cyc == 11) begin
        cmd_start  = 1'b0;
        cfg_kernel = 4'(v.k);
      end
      if (ren) rc++;
      else if (xaddr != '0) pv++;
      if (owen) begin
        if (nw < 16) begin
          ga[nw] = oaddr;
          gd[nw] = odata;
        end
        nw++;
      end
      if (cmd_done) begin
        done_at  = cyc;
        err_seen = int'(cfg_err);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    chk($sformatf("v%0d done_cycle", idx), 64'(done_at), 64'(v.done_cyc));
    chk($sformatf("v%0d cfg_err", idx), 64'(err_seen), 64'(v.err));
    chk($sformatf("v%0d write_count", idx), 64'(nw), 64'(v.n_exp));
    chk($sformatf("v%0d ren_count", idx), 64'(rc), 64'(v.ren_cnt));
    chk($sformatf("v%0d pad_xaddr_nonzero", idx), 64'(pv), 64'd0);
    for (int n = 0; n < v.n_exp && n < nw && n < 9; n++) begin
      chk($sformatf("v%0d oaddr[%0d]", idx, n), 64'(ga[n]), 64'(n));
      chk($sformatf("v%0d odata[%0d]", idx, n), 64'(gd[n]), 64'(v.exp_data[n]));
    end
    @(negedge clk);
    chk($sformatf("v%0d idle_after", idx), {61'd0, cmd_busy, owen, ren}, 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " ren"},   64'(ren),      64'd0);
    chk({tag, " xaddr"}, 64'(xaddr),    64'd0);
    chk({tag, " waddr"}, 64'(waddr),    64'd0);
    chk({tag, " owen"},  64'(owen),     64'd0);
    chk({tag, " oaddr"}, 64'(oaddr),    64'd0);
    chk({tag, " odata"}, 64'(odata),    64'd0);
    chk({tag, " busy"},  64'(cmd_busy), 64'd0);
    chk({tag, " done"},  64'(cmd_done), 64'd0);
    chk({tag, " err"},   64'(cfg_err),  64'd0);
  endtask

  initial begin
    //         w  h  k  s  p nk xm wm  n  expected data                                          done err ren
    vecs[0] = '{4, 4, 3, 1, 0, 1, 0, 0, 4, '{9, 9, 9, 9, 0, 0, 0, 0, 0},                          41, 0, 36};
    vecs[1] = '{3, 3, 3, 1, 1, 1, 0, 0, 9, '{4, 6, 4, 6, 9, 6, 4, 6, 4},                          86, 0, 49};
    vecs[2] = '{5, 5, 3, 2, 0, 1, 1, 0, 4, '{54, 72, 144, 162, 0, 0, 0, 0, 0},                    41, 0, 36};
    vecs[3] = '{2, 2, 1, 1, 0, 2, 2, 1, 8, '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                             32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                             32'h8000_0000, 32'h8000_0000, 0},                    13, 0, 8};
    vecs[4] = '{3, 3, 5, 1, 0, 1, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0},                           2, 1, 0};
    vecs[5] = '{4, 4, 3, 1, 0, 0, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0},                           2, 1, 0};
    vecs[6] = '{4, 4, 3, 0, 0, 1, 0, 0, 4, '{9, 9, 9, 9, 0, 0, 0, 0, 0},                          41, 0, 36};
    vecs[7] = '{4, 4, 3, 3, 1, 1, 0, 0, 4, '{4, 4, 4, 4, 0, 0, 0, 0, 0},                          41, 0, 16};

    rst = 1'b1;
    cmd_start = 1'b0;
    cfg_img_w = '0; cfg_img_h = '0; cfg_kernel = '0; cfg_stride = '0; cfg_pad = 1'b0; cfg_knum = '0;
    for (int a = 0; a < 64; a++) begin
      xmem[a] = 0;
      wmem[a] = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("idle");

    for (int t = 0; t < 8; t++) run_job(t, 1'b0);

    // A start pulse with a different kernel during a run must be ignored.
    run_job(0, 1'b1);

    // Reset in the middle of a run, then repeat the first job.
    @(negedge clk);
    cfg_img_w = 8'd4; cfg_img_h = 8'd4; cfg_kernel = 4'd3; cfg_stride = 2'd1;
    cfg_pad = 1'b0; cfg_knum = 4'd1;
    for (int a = 0; a < 64; a++) begin
      xmem[a] = 1;
      wmem[a] = 1;
    end
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("after_rst");
    run_job(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
